// File: rtl/hunt_pkg.sv
// Shared types and default constants for the duck-hunt match controller.
package hunt_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_END   = 2'd2
  } hunt_state_e;

  localparam int MAX_PLAYERS       = 4;
  localparam int DEF_MAG_SIZE      = 3;
  localparam int DEF_TOTAL_AMMO    = 30;
  localparam int DEF_ROUND_SECONDS = 60;

endpackage

// File: rtl/hunt_player_ammo.sv
// One shooter's magazine, reserve, score and reload-hint bookkeeping.
module hunt_player_ammo
  import hunt_pkg::*;
#(
  parameter int MAG_SIZE   = DEF_MAG_SIZE,
  parameter int TOTAL_AMMO = DEF_TOTAL_AMMO,
  parameter int SCORE_W    = 7,
  parameter int MAG_W      = 2,
  parameter int AMMO_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_play,
  input  logic               i_shot,
  input  logic               i_hit,
  input  logic               i_reload,
  output logic [MAG_W-1:0]   o_mag,
  output logic [AMMO_W-1:0]  o_ammo,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_score_nxt,
  output logic               o_show_reload,
  output logic               o_out
);

  localparam logic [MAG_W-1:0]   MAG_FULL  = MAG_W'(MAG_SIZE);
  localparam logic [AMMO_W-1:0]  AMMO_INIT = AMMO_W'(TOTAL_AMMO - MAG_SIZE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [MAG_W-1:0]   r_mag,   w_mag_nxt;
  logic [AMMO_W-1:0]  r_ammo,  w_ammo_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic               r_show,  w_show_nxt;
  logic [AMMO_W-1:0]  w_space;
  logic [AMMO_W-1:0]  w_move;

  // Rounds that fit in the magazine, capped by what is left in reserve.
  assign w_space = AMMO_W'(MAG_FULL) - AMMO_W'(r_mag);
  assign w_move  = (w_space < r_ammo) ? w_space : r_ammo;

  always_comb begin
    w_mag_nxt   = r_mag;
    w_ammo_nxt  = r_ammo;
    w_score_nxt = r_score;
    w_show_nxt  = r_show;
    if (i_load) begin
      w_mag_nxt   = MAG_FULL;
      w_ammo_nxt  = AMMO_INIT;
      w_score_nxt = '0;
      w_show_nxt  = 1'b0;
    end else if (i_play) begin
      if (i_shot) begin
        if (r_mag != '0) begin
          w_mag_nxt = r_mag - MAG_W'(1);
          if (i_hit && (r_score != SCORE_MAX)) begin
            w_score_nxt = r_score + SCORE_W'(1);
          end
        end else begin
          w_show_nxt = 1'b1;
        end
      end else if (i_reload && (r_mag < MAG_FULL) && (r_ammo != '0)) begin
        w_mag_nxt  = r_mag + w_move[MAG_W-1:0];
        w_ammo_nxt = r_ammo - w_move;
        w_show_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag   <= '0;
      r_ammo  <= '0;
      r_score <= '0;
      r_show  <= 1'b0;
    end else begin
      r_mag   <= w_mag_nxt;
      r_ammo  <= w_ammo_nxt;
      r_score <= w_score_nxt;
      r_show  <= w_show_nxt;
    end
  end

  assign o_mag         = r_mag;
  assign o_ammo        = r_ammo;
  assign o_score       = r_score;
  assign o_score_nxt   = w_score_nxt;
  assign o_show_reload = r_show;
  assign o_out         = (r_mag == '0) && (r_ammo == '0);

endmodule

// File: rtl/hunt_match_ctl.sv
// Match controller: START/PLAY/END sequencing, per-player ammo, winner decision.
// Optional round timer is built when HUNT_ROUND_TIMER_EN is defined.
module hunt_match_ctl
  import hunt_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int MAG_SIZE      = DEF_MAG_SIZE,
  parameter int TOTAL_AMMO    = DEF_TOTAL_AMMO,
  parameter int SCORE_W       = 7,
  parameter int SEC_CYCLES    = 65_000_000,
  parameter int ROUND_SECONDS = DEF_ROUND_SECONDS,
  localparam int MAG_W        = $clog2(MAG_SIZE + 1),
  localparam int AMMO_W       = $clog2(TOTAL_AMMO + 1),
  localparam int SEC_W        = $clog2(ROUND_SECONDS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_req,
  input  logic [NUM_PLAYERS-1:0]         shot,
  input  logic [NUM_PLAYERS-1:0]         hit,
  input  logic [NUM_PLAYERS-1:0]         reload,
  output logic                           start_screen_enable,
  output logic                           game_enable,
  output logic                           game_enable_posedge,
  output logic                           game_end_enable,
  output logic [NUM_PLAYERS*MAG_W-1:0]   mag,
  output logic [NUM_PLAYERS*AMMO_W-1:0]  ammo_left,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         show_reload,
  output logic [SEC_W-1:0]               seconds_left,
  output logic [1:0]                     winner,
  output logic                           tie
);

  localparam int WIN_W = $clog2(MAX_PLAYERS);

  hunt_state_e r_state, w_state_nxt;
  logic        r_start_en, r_game_en, r_game_pe, r_end_en;
  logic        w_load, w_play, w_latch_win, w_finish, w_timer_exp;
  logic [NUM_PLAYERS-1:0]         w_out;
  logic [NUM_PLAYERS*SCORE_W-1:0] w_score_nxt;
  logic [SCORE_W-1:0]             w_best;
  logic [WIN_W-1:0]               w_win_idx, r_winner;
  logic                           w_tie, r_tie;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    hunt_player_ammo #(
      .MAG_SIZE   (MAG_SIZE),
      .TOTAL_AMMO (TOTAL_AMMO),
      .SCORE_W    (SCORE_W),
      .MAG_W      (MAG_W),
      .AMMO_W     (AMMO_W)
    ) u_player (
      .clk           (clk),
      .rst_n         (rst),
      .i_load        (w_load),
      .i_play        (w_play),
      .i_shot        (shot[g]),
      .i_hit         (hit[g]),
      .i_reload      (reload[g]),
      .o_mag         (mag[g*MAG_W +: MAG_W]),
      .o_ammo        (ammo_left[g*AMMO_W +: AMMO_W]),
      .o_score       (score[g*SCORE_W +: SCORE_W]),
      .o_score_nxt   (w_score_nxt[g*SCORE_W +: SCORE_W]),
      .o_show_reload (show_reload[g]),
      .o_out         (w_out[g])
    );
  end

  assign w_finish = (&w_out) || w_timer_exp;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_latch_win = 1'b0;
    w_play      = (r_state == ST_PLAY);
    case (r_state)
      ST_START: begin
        if (start_req) begin
          w_state_nxt = ST_PLAY;
          w_load      = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_finish) begin
          w_state_nxt = ST_END;
          w_latch_win = 1'b1;
        end
      end
      ST_END: begin
        if (start_req) w_state_nxt = ST_START;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_START;
      r_start_en <= 1'b1;
      r_game_en  <= 1'b0;
      r_game_pe  <= 1'b0;
      r_end_en   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_en <= (w_state_nxt == ST_START);
      r_game_en  <= (w_state_nxt == ST_PLAY);
      r_game_pe  <= w_load;
      r_end_en   <= (w_state_nxt == ST_END);
    end
  end

  // Compare against next-cycle scores so a hit on the final PLAY cycle still counts.
  always_comb begin
    w_best    = w_score_nxt[SCORE_W-1:0];
    w_win_idx = '0;
    w_tie     = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (w_score_nxt[i*SCORE_W +: SCORE_W] > w_best) begin
        w_best    = w_score_nxt[i*SCORE_W +: SCORE_W];
        w_win_idx = WIN_W'(i);
        w_tie     = 1'b0;
      end else if (w_score_nxt[i*SCORE_W +: SCORE_W] == w_best) begin
        w_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_winner <= '0;
      r_tie    <= 1'b0;
    end else if (w_latch_win) begin
      r_winner <= w_win_idx;
      r_tie    <= w_tie;
    end
  end

`ifdef HUNT_ROUND_TIMER_EN
  localparam int                 PRE_W      = $clog2(SEC_CYCLES + 1);
  localparam logic [PRE_W-1:0]   PRE_LOAD   = PRE_W'(SEC_CYCLES - 1);
  localparam logic [SEC_W-1:0]   ROUND_INIT = SEC_W'(ROUND_SECONDS);

  logic [PRE_W-1:0] r_presc;
  logic [SEC_W-1:0] r_seconds;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc   <= PRE_LOAD;
      r_seconds <= ROUND_INIT;
    end else if (w_load) begin
      r_presc   <= PRE_LOAD;
      r_seconds <= ROUND_INIT;
    end else if (w_play && (r_seconds != '0)) begin
      if (r_presc == '0) begin
        r_presc   <= PRE_LOAD;
        r_seconds <= r_seconds - SEC_W'(1);
      end else begin
        r_presc <= r_presc - PRE_W'(1);
      end
    end
  end

  assign w_timer_exp  = (r_seconds == '0);
  assign seconds_left = r_seconds;
`else
  assign w_timer_exp  = 1'b0;
  assign seconds_left = '0;
`endif

  assign start_screen_enable = r_start_en;
  assign game_enable         = r_game_en;
  assign game_enable_posedge = r_game_pe;
  assign game_end_enable     = r_end_en;
  assign winner              = 2'(r_winner);
  assign tie                 = r_tie;

endmodule
